// File: rtl/sr_ff_bank.sv
// sr_ff_bank: N clocked SR flip-flops with a selectable S=R=1 resolution
// policy, per-channel sticky conflict flags and a saturating counter of
// cycles in which any channel saw a conflict.
//
// Interface contract: there is no handshake. Every input is sampled on each
// rising clk edge while en=1. With en=0 the whole bank (Q, flags, counter)
// is frozen, and both clear inputs are ignored. Q/conflict/cnfl_cnt are
// registered; Qn and any_cnfl are pure combinational views of those
// registers, so they never lag behind them.
module sr_ff_bank #(
    parameter int             N     = 4,
    parameter int             MODE  = 0,
    parameter int             CNT_W = 8,
    parameter logic [N-1:0]   INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     S,
    input  logic [N-1:0]     R,
    input  logic [N-1:0]     clr_flag,
    input  logic             clr_cnt,
    output logic [N-1:0]     Q,
    output logic [N-1:0]     Qn,
    output logic [N-1:0]     conflict,
    output logic             any_cnfl,
    output logic [CNT_W-1:0] cnfl_cnt
);

    // Conflict policy encodings.
    localparam int MODE_HOLD   = 0;
    localparam int MODE_SET    = 1;
    localparam int MODE_RESET  = 2;
    localparam int MODE_TOGGLE = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Reject out-of-range parameters at elaboration rather than mapping
    // them onto some legal behaviour.
    generate
        if (MODE < 0 || MODE > 3) begin : g_bad_mode
            $error("sr_ff_bank: MODE must be 0..3");
        end
        if (N < 1 || N > 32) begin : g_bad_n
            $error("sr_ff_bank: N must be 1..32");
        end
        if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
            $error("sr_ff_bank: CNT_W must be 2..16");
        end
    endgenerate

    logic [N-1:0]     q_next;
    logic [N-1:0]     flag_next;
    logic [N-1:0]     sr_both;
    logic             cycle_cnfl;
    logic [CNT_W-1:0] cnt_next;

    assign sr_both    = S & R;
    assign cycle_cnfl = |sr_both;

    // Per-channel next state: plain SR behaviour, with the S=R=1 case
    // resolved by the elaboration-time policy.
    always_comb begin
        q_next = Q;
        for (int i = 0; i < N; i++) begin
            unique case ({S[i], R[i]})
                2'b10:   q_next[i] = 1'b1;
                2'b01:   q_next[i] = 1'b0;
                2'b11: begin
                    case (MODE)
                        MODE_SET:    q_next[i] = 1'b1;
                        MODE_RESET:  q_next[i] = 1'b0;
                        MODE_TOGGLE: q_next[i] = ~Q[i];
                        default:     q_next[i] = Q[i];
                    endcase
                end
                default: q_next[i] = Q[i];
            endcase
        end
    end

    // Sticky flag: a new conflict wins over a clear in the same cycle.
    always_comb begin
        flag_next = sr_both | (conflict & ~clr_flag);
    end

    // Counter: counts cycles (not channels) with a conflict; a clear in a
    // conflict cycle restarts at 1 so that conflict is not lost.
    always_comb begin
        cnt_next = cnfl_cnt;
        if (clr_cnt) begin
            cnt_next = cycle_cnfl ? CNT_ONE : '0;
        end else if (cycle_cnfl && (cnfl_cnt != CNT_MAX)) begin
            cnt_next = cnfl_cnt + CNT_ONE;
        end
    end

    // State registers: async reset, everything frozen while en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q        <= INIT;
            conflict <= '0;
            cnfl_cnt <= '0;
        end else if (en) begin
            Q        <= q_next;
            conflict <= flag_next;
            cnfl_cnt <= cnt_next;
        end
    end

    assign Qn       = ~Q;
    assign any_cnfl = |conflict;

endmodule
